dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
- Data-memory responder: the memory end of the CPU's load/store port.
- Accepts one word request at a time from the datapath's memory stage, applies a programmable wait-state latency, performs the read or write, and returns one response pulse.
- Replaces the zero-latency data memory so the pipeline/stall logic can be exercised against a realistic slow memory.

Parameters:
- DEPTH_LOG2, 10, log2 of memory depth in 32-bit words (default 1024 words = 4 KiB).
- LATENCY, 2, wait-state cycles between acceptance and response; legal 0..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_we  input  1  1 = store (sw), 0 = load (lw).
- req_addr  input  32  byte address (ALU result z).
- req_wdata  input  32  store data (rd2).
- req_ready  output  1  responder can accept a request this cycle.
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  32  load data; valid only with resp_valid.
- resp_err  output  1  request rejected (misaligned or out of range); valid only with resp_valid.
- busy  output  1  transaction in flight (state != IDLE); drives the CPU stall.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, req_ready=0 while reset is high, resp_valid=0, resp_rdata=0, resp_err=0, busy=0. Memory array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1, the request is accepted at cycle T: req_we, req_addr and req_wdata are latched and the error check is evaluated.
  - If LATENCY=0, next state is RESP; otherwise next state is WAIT with the counter loaded to LATENCY-1.
- WAIT:
  - req_ready=0; any req_valid is ignored and not queued.
  - The counter decrements each cycle; at 0 the next state is RESP.
- Memory access on the edge entering RESP:
  - Store: mem[idx] <= wdata.
  - Load: resp_rdata <= mem[idx].
- RESP:
  - resp_valid=1 for exactly one cycle; req_ready=0.
  - Next state is IDLE.
- Latency: a request accepted in cycle T gets resp_valid in cycle T+1+LATENCY. The next request can be accepted no earlier than T+2+LATENCY.
- Store response: resp_rdata=0.
- Address check:
  - idx = (req_addr - BASE_ADDR) >> 2, using 32-bit unsigned subtraction.
  - Error if req_addr[1:0] != 0, or if req_addr < BASE_ADDR, or if idx >= 2^DEPTH_LOG2. Subtraction wrap is treated as out of range.
  - On error: no memory write, resp_rdata=0, resp_err=1, same latency as a legal access.
- Read-after-write: a load accepted after a store's RESP cycle returns the new data.
- Reset mid-transaction: the transaction is aborted, the state returns to IDLE, and no response is issued. A store whose RESP edge has not occurred is not written.
- Reset wins over req_valid in the same cycle.

Optional Feature:
- Macro DM_MMIO_EN.
- Defined:
  - Extra output port mmio_out (32 bits), reset to 0.
  - A legal-timed store to byte address 32'hFFFF_FFF0 updates mmio_out at the RESP edge; the memory array is untouched and resp_err=0.
  - A load from that address returns mmio_out.
  - This address bypasses the range check.
- Not defined: the port is absent, and 32'hFFFF_FFF0 is handled like any other out-of-range address (resp_err=1).

Test Plan:
- Reset held 2 cycles -> resp_valid=0, busy=0, req_ready=0 during reset; req_ready=1 in the first cycle after reset deasserts.
- Store 0x10 <= 32'hDEADBEEF accepted at T (LATENCY=2) -> busy=1 T+1..T+3, resp_valid=1 only at T+3 with resp_err=0. Load 0x10 accepted at T+4 -> resp_rdata=32'hDEADBEEF at T+7.
- Store to misaligned 0x12 data 0x1 -> resp_err=1 at T+3. A subsequent load 0x10 still returns 32'hDEADBEEF.
- Load from 0x1000 (index 1024, out of range) -> resp_err=1, resp_rdata=0 at T+3.
- Preload 0x20=7, issue store 0x20 <= 5, assert reset at T+1 -> no resp_valid. After reset, load 0x20 returns 7.
- req_valid held high continuously with alternating requests -> acceptances at T, T+4, T+8, with no request captured during WAIT/RESP. With LATENCY=0, resp_valid appears at T+1 and the next acceptance at T+2.

Source files
------------

// File: rtl/dm_responder.sv
// dm_responder: data-memory responder for the CPU load/store port.
// Accepts one word request at a time and applies LATENCY wait states.
// It then performs the read or write and returns a single response pulse.
// Optional feature: define DM_MMIO_EN to add a memory-mapped output register
// (mmio_out) at byte address 32'hFFFF_FFF0.
module dm_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
`ifdef DM_MMIO_EN
  ,
  output logic [31:0] mmio_out
`endif
);

  localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [31:0] MMIO_ADDR = 32'hFFFF_FFF0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state, state_next;
  logic [3:0]            cnt;
  logic [31:0]           mem [DEPTH];

  logic                  we_q, err_q, mmio_q;
  logic [31:0]           wdata_q;
  logic [DEPTH_LOG2-1:0] idx_q;

  logic [31:0]           offset;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  req_err, req_mmio;

  logic                  cur_we, cur_err, cur_mmio;
  logic [31:0]           cur_wdata;
  logic [DEPTH_LOG2-1:0] cur_idx;
  logic                  access;

  // Decode the incoming address: word index, MMIO hit and error.
  // A wrapped subtraction lands far out of range and is rejected.
  always_comb begin
    offset   = req_addr - BASE_ADDR;
    req_idx  = offset[DEPTH_LOG2+1:2];
`ifdef DM_MMIO_EN
    req_mmio = (req_addr == MMIO_ADDR);
`else
    req_mmio = 1'b0;
`endif
    req_err  = !req_mmio &&
               ((req_addr[1:0] != 2'b00) ||
                (req_addr < BASE_ADDR) ||
                ((offset >> (DEPTH_LOG2 + 2)) != 32'd0));
  end

  // Select the transaction being serviced.
  // In IDLE this is the live request, which matters for zero latency.
  // Otherwise it is the request latched at acceptance.
  always_comb begin
    cur_we    = we_q;
    cur_err   = err_q;
    cur_mmio  = mmio_q;
    cur_wdata = wdata_q;
    cur_idx   = idx_q;
    if (state == IDLE) begin
      cur_we    = req_we;
      cur_err   = req_err;
      cur_mmio  = req_mmio;
      cur_wdata = req_wdata;
      cur_idx   = req_idx;
    end
  end

  // Next-state logic: accept in IDLE, count wait states, pulse RESP once.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req_valid) state_next = (LATENCY == 0) ? RESP : WAIT;
      WAIT: if (cnt == 4'd0) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign access     = !reset && (state_next == RESP);
  assign req_ready  = (state == IDLE) && !reset;
  assign resp_valid = (state == RESP) && !reset;
  assign busy       = (state != IDLE) && !reset;

  // State, request latches, wait counter and response data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      mmio_q     <= 1'b0;
      wdata_q    <= 32'd0;
      idx_q      <= '0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        err_q   <= req_err;
        mmio_q  <= req_mmio;
        wdata_q <= req_wdata;
        idx_q   <= req_idx;
        cnt     <= 4'(LATENCY - 1);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (state_next == RESP) begin
        resp_err <= cur_err;
        if (cur_we || cur_err)
          resp_rdata <= 32'd0;
`ifdef DM_MMIO_EN
        else if (cur_mmio)
          resp_rdata <= mmio_out;
`endif
        else
          resp_rdata <= mem[cur_idx];
      end
    end
  end

  // Memory array write on the edge entering RESP; contents are never reset.
  always_ff @(posedge clk) begin
    if (access && cur_we && !cur_err && !cur_mmio)
      mem[cur_idx] <= cur_wdata;
  end

`ifdef DM_MMIO_EN
  // Memory-mapped output register, written by a store to MMIO_ADDR.
  always_ff @(posedge clk) begin
    if (reset)
      mmio_out <= 32'd0;
    else if (access && cur_we && cur_mmio)
      mmio_out <= cur_wdata;
  end
`endif

endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: self-checking bench for dm_responder.
// One instance uses the default LATENCY of 2; a second uses LATENCY 0.
// Expected values come from a word-addressed reference memory keyed by byte address.
module tb_dm_responder;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;

  logic        req0_valid, req0_we;
  logic [31:0] req0_addr, req0_wdata;
  logic        req0_ready, resp0_valid, resp0_err, busy0;
  logic [31:0] resp0_rdata;

`ifdef DM_MMIO_EN
  logic [31:0] mmio_out, mmio0_out;
`endif

  int num_checks = 0;
  int num_fail   = 0;

  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] ref_mmio = 32'd0;

  dm_responder #(.DEPTH_LOG2(10), .LATENCY(LAT), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy)
`ifdef DM_MMIO_EN
    , .mmio_out(mmio_out)
`endif
  );

  dm_responder #(.DEPTH_LOG2(10), .LATENCY(0), .BASE_ADDR(32'h0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req0_valid), .req_we(req0_we),
    .req_addr(req0_addr), .req_wdata(req0_wdata), .req_ready(req0_ready),
    .resp_valid(resp0_valid), .resp_rdata(resp0_rdata), .resp_err(resp0_err),
    .busy(busy0)
`ifdef DM_MMIO_EN
    , .mmio_out(mmio0_out)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic is_mmio(input logic [31:0] a);
`ifdef DM_MMIO_EN
    return a == 32'hFFFF_FFF0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic exp_err(input logic [31:0] a);
    if (is_mmio(a)) return 1'b0;
    return (a % 4 != 0) || (longint'(a) >= longint'(DEPTH) * 4);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    assert (got === exp) else begin
      num_fail++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one request on the LATENCY=2 instance, called just after a rising edge.
  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input string tag);
    logic        e;
    logic [31:0] d;
    e = exp_err(addr);
    d = 32'd0;
    if (!we && !e) begin
      if (is_mmio(addr)) d = ref_mmio;
      else if (ref_mem.exists(addr)) d = ref_mem[addr];
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    checkOutput({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
    nextCycle();
    req_valid = 1'b0; req_we = $urandom_range(0, 1);
    req_addr = $urandom; req_wdata = $urandom;
    for (int k = 0; k < LAT; k++) begin
      checkOutput({tag, ".wait_valid"}, {31'd0, resp_valid}, 32'd0);
      checkOutput({tag, ".wait_busy"}, {31'd0, busy}, 32'd1);
      nextCycle();
    end
    checkOutput({tag, ".resp_valid"}, {31'd0, resp_valid}, 32'd1);
    checkOutput({tag, ".resp_busy"}, {31'd0, busy}, 32'd1);
    checkOutput({tag, ".resp_err"}, {31'd0, resp_err}, {31'd0, e});
    checkOutput({tag, ".resp_rdata"}, resp_rdata, d);
    if (we && !e) begin
      if (is_mmio(addr)) ref_mmio = wdata;
      else ref_mem[addr] = wdata;
    end
    nextCycle();
    checkOutput({tag, ".idle_valid"}, {31'd0, resp_valid}, 32'd0);
    checkOutput({tag, ".idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] a, d;
    logic        w;
    int          period;
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = 32'd0; req0_wdata = 32'd0;
    $display("[TB] reset phase");
    for (int c = 0; c < 2; c++) begin
      nextCycle();
      checkOutput("reset.resp_valid", {31'd0, resp_valid}, 32'd0);
      checkOutput("reset.busy", {31'd0, busy}, 32'd0);
      checkOutput("reset.req_ready", {31'd0, req_ready}, 32'd0);
    end
    reset = 1'b0;
    #1;
    checkOutput("post_reset.req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("post_reset.req0_ready", {31'd0, req0_ready}, 32'd1);

    $display("[TB] directed accesses");
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, "store_10");
    applyStimulus(1'b0, 32'h10, 32'h0, "load_10");
    applyStimulus(1'b1, 32'h12, 32'h1, "store_misaligned");
    applyStimulus(1'b0, 32'h10, 32'h0, "load_10_again");
    applyStimulus(1'b0, 32'h1000, 32'h0, "load_oob");
    applyStimulus(1'b1, 32'hFFC, 32'hCAFE0001, "store_last");
    applyStimulus(1'b0, 32'hFFC, 32'h0, "load_last");
    applyStimulus(1'b1, 32'h1000, 32'h55, "store_oob");
    applyStimulus(1'b0, 32'hFFFF_FFF0, 32'h0, "load_mmio_addr");
    applyStimulus(1'b1, 32'hFFFF_FFF0, 32'h1234, "store_mmio_addr");
    applyStimulus(1'b0, 32'hFFFF_FFF0, 32'h0, "load_mmio_back");

    $display("[TB] reset during a store");
    applyStimulus(1'b1, 32'h20, 32'd7, "preload_20");
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'd5;
    checkOutput("abort.ready", {31'd0, req_ready}, 32'd1);
    nextCycle();
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("abort.valid_in_reset", {31'd0, resp_valid}, 32'd0);
    nextCycle();
    reset = 1'b0;
    for (int c = 0; c < LAT + 2; c++) begin
      checkOutput("abort.no_resp", {31'd0, resp_valid}, 32'd0);
      checkOutput("abort.busy", {31'd0, busy}, 32'd0);
      nextCycle();
    end
    applyStimulus(1'b0, 32'h20, 32'h0, "load_20_after_abort");

    $display("[TB] continuous req_valid");
    period = LAT + 2;
    for (int c = 0; c < 3 * period; c++) begin
      req_valid = 1'b1;
      req_addr  = 32'h40;
      if (c % period == 0) begin
        req_we    = (c / period) % 2 == 0;
        req_wdata = 32'd100 + c;
        if (req_we) ref_mem[32'h40] = req_wdata;
      end else begin
        req_we    = 1'b1;
        req_wdata = 32'hBAD0_0000 | c;
      end
      checkOutput("stream.ready", {31'd0, req_ready}, {31'd0, c % period == 0});
      checkOutput("stream.valid", {31'd0, resp_valid}, {31'd0, c % period == period - 1});
      if (c == 2 * period - 1)
        checkOutput("stream.load_data", resp_rdata, 32'd100);
      nextCycle();
    end
    req_valid = 1'b0;
    applyStimulus(1'b0, 32'h40, 32'h0, "stream.final_load");

    $display("[TB] zero-latency instance");
    d = $urandom;
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 32'h8; req0_wdata = d;
    checkOutput("lat0.ready", {31'd0, req0_ready}, 32'd1);
    nextCycle();
    req0_valid = 1'b0; req0_wdata = ~d;
    checkOutput("lat0.store_valid", {31'd0, resp0_valid}, 32'd1);
    checkOutput("lat0.store_err", {31'd0, resp0_err}, 32'd0);
    checkOutput("lat0.store_rdata", resp0_rdata, 32'd0);
    nextCycle();
    checkOutput("lat0.ready_again", {31'd0, req0_ready}, 32'd1);
    for (int c = 0; c < 6; c++) begin
      req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h8;
      checkOutput("lat0.stream_ready", {31'd0, req0_ready}, {31'd0, c % 2 == 0});
      checkOutput("lat0.stream_valid", {31'd0, resp0_valid}, {31'd0, c % 2 == 1});
      if (c % 2 == 1) checkOutput("lat0.stream_rdata", resp0_rdata, d);
      nextCycle();
    end
    req0_valid = 1'b0;

    $display("[TB] randomized accesses");
    for (int i = 0; i < 30; i++) begin
      int r;
      r = $urandom_range(0, 9);
      w = $urandom_range(0, 1);
      d = $urandom;
      if (r == 0)      a = ($urandom_range(0, 63) * 4) + $urandom_range(1, 3);
      else if (r == 1) a = 32'h1000 + $urandom_range(0, 255) * 4;
      else if (r == 2) a = 32'hFFFF_FFF0;
      else             a = $urandom_range(0, 31) * 4;
      if (!w && !exp_err(a) && !is_mmio(a) && !ref_mem.exists(a)) w = 1'b1;
      applyStimulus(w, a, d, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
